// File: rtl/mult_share_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_share_pkg
// Description : Shared types and constants for the multiplier sequencing
//               controller: FSM state encoding, default operand width and
//               the requester index type.
// Revision    : 1.0  initial release
// ============================================================================
package mult_share_pkg;

    // Default multiplier operand width (iterations per job).
    localparam int DEFAULT_WIDTH = 8;

    // Index of one of the two requesters (0 = switch panel, 1 = secondary).
    typedef logic req_idx_t;

    // Controller states. The EVAL decision has no state of its own: it is
    // folded into the transitions out of LOAD and SHIFT.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_ADD     = 3'd2,
        ST_SUB     = 3'd3,
        ST_SHIFT   = 3'd4,
        ST_DONE    = 3'd5,
        ST_RELEASE = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mult_share_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-input round-robin arbiter. The winner is combinational
//               from req; the tie pointer records the last tie winner and
//               flips only when a tie is resolved with advance high.
// Ports       : Clk, Reset (sync, active-high)
//               req[1:0]    request vector
//               advance     grant is being taken this cycle
//               winner[1:0] one-hot winner (0 when no request)
// Revision    : 1.0  initial release
// ============================================================================
module rr_arb2
    import mult_share_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] winner
);

    // Requester that won the most recent tie; resets to 1 so that
    // requester 0 wins the first tie.
    req_idx_t r_last;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_last <= 1'b1;
        end else if (advance && (&req)) begin
            r_last <= ~r_last;
        end
    end

    always_comb begin
        winner = 2'b00;
        if (&req) begin
            winner = r_last ? 2'b01 : 2'b10;
        end else begin
            winner = req;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mult_share_ctrl
// Description : Sequencing controller and two-port arbiter for a shared
//               WIDTH-bit add/shift Booth-style multiplier datapath. Grants
//               one requester, issues Clr_Ld, then WIDTH iterations of
//               optional Add (or Sub on the last iteration) followed by
//               Shift, and pulses done to the owner.
// Ports       : Clk, Reset (sync, active-high)
//               req[1:0]   level job requests, held until done is seen
//               M          current LSB of the datapath B register
//               grant[1:0] one-hot owner / operand mux select
//               done[1:0]  one-cycle completion pulse to the owner
//               busy       high outside IDLE
//               Clr_Ld, Add, Sub, Shift  datapath controls (Moore)
// Options     : MULT_SHARE_PERF_EN adds job_cnt[15:0] (saturating count of
//               completed jobs) and last_cycles (LOAD-to-done cycle count
//               of the last completed job).
// Revision    : 1.0  initial release
// ============================================================================
module mult_share_ctrl
    import mult_share_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [1:0] req,
    input  logic       M,
    output logic [1:0] grant,
    output logic [1:0] done,
    output logic       busy,
    output logic       Clr_Ld,
    output logic       Add,
    output logic       Sub,
    output logic       Shift
`ifdef MULT_SHARE_PERF_EN
    ,
    output logic [15:0]                 job_cnt,
    output logic [$clog2(WIDTH+1)+1:0]  last_cycles
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_iters     = CNT_W'(WIDTH);

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_grant;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_iter;
    logic [1:0]       w_winner;
    logic             w_owner_req;
    state_t           w_eval;

    rr_arb2 u_arb (
        .Clk     (Clk),
        .Reset   (Reset),
        .req     (req),
        .advance (r_state == ST_IDLE),
        .winner  (w_winner)
    );

    assign w_owner_req = |(req & r_grant);

    // Index of the iteration about to be evaluated. Out of LOAD it is the
    // freshly cleared count; out of SHIFT it is the count after this shift.
    assign w_iter = (r_state == ST_LOAD) ? '0 : r_cnt + 1'b1;

    // Merged EVAL decision: M is the B LSB as it will stand for the next
    // iteration.
    always_comb begin
        w_eval = ST_SHIFT;
        if (M) begin
            w_eval = (w_iter == c_last_iter) ? ST_SUB : ST_ADD;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (|req) w_next = ST_LOAD;
            ST_LOAD:    w_next = w_eval;
            ST_ADD:     w_next = ST_SHIFT;
            ST_SUB:     w_next = ST_SHIFT;
            ST_SHIFT:   w_next = (w_iter == c_iters) ? ST_DONE : w_eval;
            ST_DONE:    w_next = ST_RELEASE;
            ST_RELEASE: if (!w_owner_req) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Iteration counter: cleared in LOAD, advanced once per shift, and
    // bounded by WIDTH because SHIFT leaves for DONE at that point.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cnt <= '0;
        end else if (r_state == ST_LOAD) begin
            r_cnt <= '0;
        end else if (r_state == ST_SHIFT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Owner is latched only from IDLE-cycle requests and held through
    // RELEASE so a still-asserted req cannot restart a job.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_grant <= 2'b00;
        end else if ((r_state == ST_IDLE) && (|req)) begin
            r_grant <= w_winner;
        end else if ((r_state == ST_RELEASE) && !w_owner_req) begin
            r_grant <= 2'b00;
        end
    end

    assign grant  = r_grant;
    assign done   = (r_state == ST_DONE) ? r_grant : 2'b00;
    assign busy   = (r_state != ST_IDLE);
    assign Clr_Ld = (r_state == ST_LOAD);
    assign Add    = (r_state == ST_ADD);
    assign Sub    = (r_state == ST_SUB);
    assign Shift  = (r_state == ST_SHIFT);

`ifdef MULT_SHARE_PERF_EN
    logic [15:0]      r_job_cnt;
    logic [CNT_W+1:0] r_cyc;
    logic [CNT_W+1:0] r_last_cycles;

    // r_cyc equals the number of cycles since LOAD when DONE is reached.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_job_cnt     <= '0;
            r_cyc         <= '0;
            r_last_cycles <= '0;
        end else begin
            case (r_state)
                ST_LOAD:  r_cyc <= (CNT_W+2)'(1);
                ST_ADD,
                ST_SUB,
                ST_SHIFT: r_cyc <= r_cyc + 1'b1;
                ST_DONE: begin
                    r_last_cycles <= r_cyc;
                    if (r_job_cnt != 16'hFFFF) begin
                        r_job_cnt <= r_job_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign job_cnt     = r_job_cnt;
    assign last_cycles = r_last_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_share_ctrl
// Description : Self-checking bench for mult_share_ctrl. A small behavioural
//               B-register model supplies M; expected command sequences,
//               latencies and arbitration outcomes come from a reference
//               model built from the operand bits.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mult_share_ctrl;

    localparam int W = 8;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [1:0] req;
    logic       M;
    logic [1:0] grant;
    logic [1:0] done;
    logic       busy;
    logic       Clr_Ld;
    logic       Add;
    logic       Sub;
    logic       Shift;
`ifdef MULT_SHARE_PERF_EN
    logic [15:0]              job_cnt;
    logic [$clog2(W+1)+1:0]   last_cycles;
`endif

    mult_share_ctrl #(.WIDTH(W)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .req    (req),
        .M      (M),
        .grant  (grant),
        .done   (done),
        .busy   (busy),
        .Clr_Ld (Clr_Ld),
        .Add    (Add),
        .Sub    (Sub),
        .Shift  (Shift)
`ifdef MULT_SHARE_PERF_EN
        ,
        .job_cnt     (job_cnt),
        .last_cycles (last_cycles)
`endif
    );

    always #5 Clk = ~Clk;

    // ---------------- datapath B register model ----------------
    logic [W-1:0] opnd0, opnd1, opnd_sel, b_reg;
    assign opnd_sel = grant[1] ? opnd1 : opnd0;

    always @(posedge Clk) begin
        if (Clr_Ld)     b_reg <= opnd_sel;
        else if (Shift) b_reg <= {b_reg[W-1], b_reg[W-1:1]};
    end

    // M is the LSB the B register holds for the next evaluation.
    always_comb begin
        if (Clr_Ld)     M = opnd_sel[0];
        else if (Shift) M = b_reg[1];
        else            M = b_reg[0];
    end

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    int         obs_ops[$];
    int         exp_ops[$];
    int         done_k;
    logic [1:0] done_val;
    logic [1:0] grant_at_load;
    int         load_wait;
    bit         load_found;
    int         model_last;   // requester that won the last tie

    // op codes: 0 none, 1 add, 2 sub, 3 shift, 4 clr_ld, 5 several at once
    function automatic void build_expected(input logic [W-1:0] b);
        exp_ops.delete();
        for (int i = 0; i < W; i++) begin
            if (b[i]) exp_ops.push_back((i == W - 1) ? 2 : 1);
            exp_ops.push_back(3);
        end
    endfunction

    function automatic int popcount(input logic [W-1:0] b);
        int n = 0;
        for (int i = 0; i < W; i++) n += int'(b[i]);
        return n;
    endfunction

    function automatic bit ops_equal();
        if (obs_ops.size() != exp_ops.size()) return 1'b0;
        foreach (exp_ops[i]) if (obs_ops[i] != exp_ops[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int count_op(input int code);
        int n = 0;
        foreach (obs_ops[i]) if (obs_ops[i] == code) n++;
        return n;
    endfunction

    // Tie resolution per the round-robin rule; updates the model pointer.
    function automatic int model_winner(input logic [1:0] r);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
        model_last = (model_last == 1) ? 0 : 1;
        return model_last;
    endfunction

    // Waits for LOAD, then records one op code per cycle until done.
    // drop_at > 0 clears the owner's req that many cycles after LOAD.
    task automatic capture_job(input int drop_at);
        int n;
        obs_ops.delete();
        done_k = -1; done_val = 2'b00; load_found = 1'b0;
        load_wait = 0; grant_at_load = 2'b00;
        for (int i = 1; i <= 10; i++) begin
            @(negedge Clk);
            if (Clr_Ld === 1'b1) begin
                load_found = 1'b1; load_wait = i; grant_at_load = grant;
                break;
            end
        end
        if (!load_found) return;
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clk);
            if (done !== 2'b00) begin
                done_k = k; done_val = done;
                break;
            end
            n = int'(Clr_Ld) + int'(Add) + int'(Sub) + int'(Shift);
            if (n > 1)       obs_ops.push_back(5);
            else if (Clr_Ld) obs_ops.push_back(4);
            else if (Add)    obs_ops.push_back(1);
            else if (Sub)    obs_ops.push_back(2);
            else if (Shift)  obs_ops.push_back(3);
            else             obs_ops.push_back(0);
            if (k == drop_at) req = req & ~grant_at_load;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1; req = 2'b00;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        model_last = 1;
        @(negedge Clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b want=00", grant); end
        total++; if (done !== 2'b00) begin bad++; $display("FAIL reset_done got=%b want=00", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if ({Clr_Ld, Add, Sub, Shift} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctrl got=%b want=0000", {Clr_Ld, Add, Sub, Shift});
        end
    endtask

    task automatic test_add_path();
        opnd0 = 8'h05; build_expected(opnd0);
        req = 2'b01;
        capture_job(0);
        total++; if (!load_found || grant_at_load !== 2'b01) begin
            bad++; $display("FAIL add_grant got=%b want=01 load=%0b", grant_at_load, load_found);
        end
        total++; if (!ops_equal()) begin
            bad++; $display("FAIL add_ops got_len=%0d want_len=%0d", obs_ops.size(), exp_ops.size());
        end
        total++; if (done_k != 11 || done_val !== 2'b01) begin
            bad++; $display("FAIL add_done got=%0d/%b want=11/01", done_k, done_val);
        end
        total++; if (count_op(2) != 0) begin bad++; $display("FAIL add_nosub got=%0d want=0", count_op(2)); end
        req = 2'b00;
        repeat (2) @(negedge Clk);
        total++; if (busy !== 1'b0 || grant !== 2'b00) begin
            bad++; $display("FAIL add_idle got busy=%b grant=%b want 0/00", busy, grant);
        end
    endtask

    task automatic test_sub_path();
        opnd1 = 8'h80; build_expected(opnd1);
        req = 2'b10;
        capture_job(0);
        total++; if (!load_found || grant_at_load !== 2'b10) begin
            bad++; $display("FAIL sub_grant got=%b want=10", grant_at_load);
        end
        total++; if (!ops_equal()) begin
            bad++; $display("FAIL sub_ops got_len=%0d want_len=%0d", obs_ops.size(), exp_ops.size());
        end
        total++; if (done_k != 10 || done_val !== 2'b10) begin
            bad++; $display("FAIL sub_done got=%0d/%b want=10/10", done_k, done_val);
        end
        total++; if (count_op(1) != 0 || count_op(2) != 1) begin
            bad++; $display("FAIL sub_counts got add=%0d sub=%0d want 0/1", count_op(1), count_op(2));
        end
        req = 2'b00;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_tie();
        int w;
        do_reset();
        opnd0 = 8'($urandom); opnd1 = 8'($urandom);
        req = 2'b11;
        w = model_winner(2'b11);
        capture_job(0);
        total++; if (!load_found || w != 0 || grant_at_load !== 2'b01 || done_val !== 2'b01) begin
            bad++; $display("FAIL tie_first got=%b/%b want=01/01", grant_at_load, done_val);
        end
        req = 2'b10;
        build_expected(opnd1);
        capture_job(0);
        total++; if (!load_found || load_wait != 3 || grant_at_load !== 2'b10) begin
            bad++; $display("FAIL tie_second got wait=%0d grant=%b want 3/10", load_wait, grant_at_load);
        end
        total++; if (!ops_equal() || done_k != 1 + W + popcount(opnd1) || done_val !== 2'b10) begin
            bad++; $display("FAIL tie_second_job got=%0d/%b want=%0d/10", done_k, done_val, 1 + W + popcount(opnd1));
        end
        req = 2'b00;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_hold_release();
        opnd0 = 8'($urandom);
        req = 2'b01;
        capture_job(0);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            total++; if (grant !== 2'b01 || busy !== 1'b1 || Clr_Ld !== 1'b0 || done !== 2'b00) begin
                bad++; $display("FAIL hold_release got grant=%b busy=%b clr=%b done=%b", grant, busy, Clr_Ld, done);
            end
        end
        req = 2'b00;
        @(negedge Clk);
        total++; if (busy !== 1'b0 || grant !== 2'b00) begin
            bad++; $display("FAIL hold_exit got busy=%b grant=%b want 0/00", busy, grant);
        end
    endtask

    task automatic test_reset_mid();
        bit seen_done = 1'b0;
        int w;
        opnd0 = 8'hFF;
        req = 2'b01;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (Clr_Ld) break;
        end
        repeat (4) begin
            @(negedge Clk);
            if (done !== 2'b00) seen_done = 1'b1;
        end
        Reset = 1'b1;
        @(negedge Clk);
        total++; if (seen_done || {grant, done, busy, Clr_Ld, Add, Sub, Shift} !== 9'd0) begin
            bad++; $display("FAIL reset_mid got=%b done_seen=%0b want=0", {grant, done, busy, Clr_Ld, Add, Sub, Shift}, seen_done);
        end
        Reset = 1'b0; req = 2'b00; model_last = 1;
        @(negedge Clk);
        req = 2'b11;
        w = model_winner(2'b11);
        capture_job(0);
        total++; if (!load_found || w != 0 || grant_at_load !== 2'b01) begin
            bad++; $display("FAIL reset_mid_ptr got=%b want=01", grant_at_load);
        end
        req = 2'b00;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_random();
        logic [1:0] pat, wv, lv;
        int w, drop;
        for (int j = 0; j < 16; j++) begin
            pat = 2'($urandom_range(1, 3));
            opnd0 = 8'($urandom); opnd1 = 8'($urandom);
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0;
            w = model_winner(pat);
            wv = (w == 0) ? 2'b01 : 2'b10;
            build_expected((w == 0) ? opnd0 : opnd1);
            req = pat;
            capture_job(drop);
            total++; if (!load_found || grant_at_load !== wv || !ops_equal() ||
                         done_k != 1 + W + popcount((w == 0) ? opnd0 : opnd1) || done_val !== wv) begin
                bad++; $display("FAIL rand_job%0d got grant=%b done=%0d/%b want grant=%b done=%0d", j,
                                grant_at_load, done_k, done_val, wv, 1 + W + popcount((w == 0) ? opnd0 : opnd1));
            end
            if (pat == 2'b11) begin
                lv = ~wv;
                req = lv;
                build_expected((w == 0) ? opnd1 : opnd0);
                capture_job(0);
                total++; if (!load_found || load_wait != 3 || grant_at_load !== lv || !ops_equal() || done_val !== lv) begin
                    bad++; $display("FAIL rand_pend%0d got wait=%0d grant=%b done=%b want 3/%b/%b", j,
                                    load_wait, grant_at_load, done_val, lv, lv);
                end
            end
            req = 2'b00;
            repeat (2) @(negedge Clk);
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL rand_idle%0d got busy=%b want 0", j, busy); end
        end
    endtask

`ifdef MULT_SHARE_PERF_EN
    task automatic test_perf();
        logic [W-1:0] ops [3];
        ops[0] = 8'h00; ops[1] = 8'h05; ops[2] = 8'hFF;
        do_reset();
        total++; if (job_cnt !== 16'd0 || last_cycles !== '0) begin
            bad++; $display("FAIL perf_reset got=%0d/%0d want=0/0", job_cnt, last_cycles);
        end
        for (int i = 0; i < 3; i++) begin
            opnd0 = ops[i];
            req = 2'b01;
            capture_job(0);
            req = 2'b00;
            @(negedge Clk);
            total++; if (job_cnt !== 16'(i + 1) || int'(last_cycles) != 1 + W + popcount(ops[i])) begin
                bad++; $display("FAIL perf_job%0d got=%0d/%0d want=%0d/%0d", i, job_cnt, last_cycles, i + 1, 1 + W + popcount(ops[i]));
            end
            @(negedge Clk);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; req = 2'b00; opnd0 = '0; opnd1 = '0; model_last = 1;
        test_reset();
        test_add_path();
        test_sub_path();
        test_tie();
        test_hold_release();
        test_reset_mid();
        test_random();
`ifdef MULT_SHARE_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
